bdeser: RTL and testbench
=========================

BDESER -- requirements
Module: bdeser

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, number of data bits per word (legal range 2..32).
REQ-002 The block SHALL have port clock, input, 1, rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port sin_valid, input, 1, serial bit present on sin this cycle.
REQ-005 The block SHALL have port sin, input, 1, serial data bit.
REQ-006 The block SHALL have port ssl, input, 1, bit order: 1 = MSB first (left shift), 0 = LSB first (right shift).
REQ-007 The block SHALL have port clr, input, 1, synchronous abort of the partial word.
REQ-008 The block SHALL have port res, output, WIDTH, assembled word.
REQ-009 The block SHALL have port res_valid, output, 1, res holds an undelivered word.
REQ-010 The block SHALL have port res_ready, input, 1, consumer accepts res this cycle.
REQ-011 The block SHALL have port overrun, output, 1, one-cycle pulse when a completed word is dropped.
REQ-012 The block SHALL have port parity_err, output, 1, parity status of the word on res.

Function
REQ-013 The block SHALL accept one bit per cycle in which sin_valid=1, with no backpressure on the serial side.
REQ-014 The block SHALL use an FSM with states IDLE (no bits held), SHIFT (1..WIDTH-1 data bits held) and, with the parity macro only, PAR (WIDTH data bits held, parity bit awaited).
REQ-015 The block SHALL latch ssl on the first accepted bit of a word, leave IDLE for SHIFT, and ignore ssl changes until that word completes.
REQ-016 With latched ssl=1, each accepted bit SHALL shift in as shreg <= {shreg[WIDTH-2:0], sin}; with latched ssl=0, as shreg <= {sin, shreg[WIDTH-1:1]}.
REQ-017 A bit counter SHALL count accepted data bits 0..WIDTH-1 and return to 0 on word completion.
REQ-018 On word completion, the block SHALL return to IDLE.
REQ-019 On word completion, if res_valid=0 or res_ready=1, the block SHALL load res and set res_valid=1 in the next cycle, giving one cycle of latency after the completing bit.
REQ-020 On word completion with res_valid=1 and res_ready=0, the block SHALL drop the new word, keep res unchanged and pulse overrun for exactly one cycle.
REQ-021 When res_ready=1 and res_valid=1 with no word completing, res_valid SHALL clear in the next cycle; res SHALL keep its last value.
REQ-022 clr=1 SHALL return the FSM to IDLE and zero the counter and shreg in the next cycle; it SHALL NOT affect res, res_valid or parity_err.
REQ-023 clr=1 SHALL take priority over a simultaneous sin_valid, and that bit SHALL be discarded.
REQ-024 Gaps in sin_valid SHALL hold all state; there SHALL be no timeout.

Reset
REQ-025 While reset=0, the block SHALL force res=0, res_valid=0, overrun=0, parity_err=0, shreg=0, counter=0, latched ssl=0 and state IDLE, regardless of clock.
REQ-026 Reset asserted mid-word SHALL discard the partial word; the first bit accepted after release SHALL start a new word.

Configuration
REQ-027 With BDESER_PARITY_EN defined, after WIDTH data bits the FSM SHALL enter PAR, take the next accepted bit as an even-parity bit, and only then complete the word.
REQ-028 With BDESER_PARITY_EN defined, parity_err SHALL load together with res as (XOR of data bits) XOR (parity bit).
REQ-029 With BDESER_PARITY_EN defined, a dropped word (REQ-020) SHALL NOT update parity_err.
REQ-030 With BDESER_PARITY_EN undefined, the PAR state SHALL NOT exist, a word SHALL complete on its WIDTH-th bit, and parity_err SHALL be constant 0.
REQ-031 The port list SHALL be identical with and without BDESER_PARITY_EN.

Verification
REQ-032 The bench SHALL cover: WIDTH=4, no macro, ssl=1, bits 1,0,1,1 on consecutive cycles, res_ready=0 -> res=4'b1011 and res_valid=1 on the cycle after the 4th bit.
REQ-033 The bench SHALL cover: ssl=0, bits 1,0,1,1 -> res=4'b1101; ssl toggled after the 1st bit -> same result.
REQ-034 The bench SHALL cover: word 1011 (ssl=1) left unread, then word 0110 completed with res_ready=0 -> overrun pulses once, res stays 4'b1011, res_valid stays 1.
REQ-035 The bench SHALL cover: res_ready=1 in the same cycle as the completing bit of 0110 while 1011 is held -> res=4'b0110, res_valid=1, overrun=0.
REQ-036 The bench SHALL cover: 2 bits accepted, then reset pulsed low (or clr=1), then bits 0,0,1,1 with ssl=1 -> res=4'b0011 and all outputs 0 during reset.
REQ-037 The bench SHALL cover: BDESER_PARITY_EN defined, ssl=1, bits 1,0,1,1 then parity bit 0 -> res=4'b1011 with parity_err=1; the same word with parity bit 1 -> parity_err=0.

Source files
------------

// File: rtl/bdeser.sv
`default_nettype none
// ============================================================================
// Module   : bdeser
// Purpose  : Serial-to-parallel deserializer. Accepts one bit per cycle while
//            sin_valid is high, assembles WIDTH-bit words in the order chosen
//            by ssl (latched on the first bit of each word) and presents them
//            on res with a valid/ready handshake. A completed word arriving
//            while res still holds an unread word is dropped and flagged on
//            overrun.
// Optional : BDESER_PARITY_EN - each word is followed by one even-parity bit;
//            parity_err reports the check result for the word on res.
//            Without the macro parity_err is tied to 0.
// Revision : 1.0 - initial release
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   sin_valid   in   serial bit present on sin this cycle
//   sin         in   serial data bit
//   ssl         in   bit order: 1 = MSB first, 0 = LSB first
//   clr         in   synchronous abort of the partial word
//   res         out  assembled word
//   res_valid   out  res holds an undelivered word
//   res_ready   in   consumer accepts res this cycle
//   overrun     out  one-cycle pulse when a completed word is dropped
//   parity_err  out  parity status of the word on res
// ============================================================================
module bdeser #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sin_valid,
    input  logic             sin,
    input  logic             ssl,
    input  logic             clr,
    output logic [WIDTH-1:0] res,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             overrun,
    output logic             parity_err
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef BDESER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH-1:0]   shreg_q,     shreg_d;
    logic               ssl_q,       ssl_d;
    logic [WIDTH-1:0]   res_q,       res_d;
    logic               res_valid_q, res_valid_d;
    logic               overrun_q,   overrun_d;
`ifdef BDESER_PARITY_EN
    logic               perr_q,      perr_d;
    logic               perr_w;
`endif

    logic               order_w;
    logic [WIDTH-1:0]   shifted_w;
    logic               done_w;
    logic [WIDTH-1:0]   word_w;

    // The first bit of a word uses the live ssl; later bits use the copy
    // latched when the word started.
    assign order_w   = (state_q == IDLE) ? ssl : ssl_q;
    assign shifted_w = order_w ? {shreg_q[WIDTH-2:0], sin}
                               : {sin, shreg_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        ssl_d       = ssl_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        overrun_d   = 1'b0;
        done_w      = 1'b0;
        word_w      = shreg_q;
`ifdef BDESER_PARITY_EN
        perr_d      = perr_q;
        perr_w      = 1'b0;
`endif

        // Serial side: clr wins over a bit presented in the same cycle.
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
        end else if (sin_valid) begin
            if (state_q == IDLE) begin
                ssl_d = ssl;
            end
`ifdef BDESER_PARITY_EN
            if (state_q == PAR) begin
                // Even parity: data bits XOR parity bit must be 0.
                done_w  = 1'b1;
                word_w  = shreg_q;
                perr_w  = (^shreg_q) ^ sin;
                state_d = IDLE;
                cnt_d   = '0;
                shreg_d = '0;
            end else begin
                shreg_d = shifted_w;
                if (cnt_q == LAST_BIT) begin
                    state_d = PAR;
                    cnt_d   = '0;
                end else begin
                    state_d = SHIFT;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
`else
            if (cnt_q == LAST_BIT) begin
                done_w  = 1'b1;
                word_w  = shifted_w;
                state_d = IDLE;
                cnt_d   = '0;
                shreg_d = '0;
            end else begin
                shreg_d = shifted_w;
                state_d = SHIFT;
                cnt_d   = cnt_q + CNT_W'(1);
            end
`endif
        end

        // Output side: a completed word lands only if the holding register
        // is free or being emptied this cycle; otherwise it is dropped.
        if (done_w) begin
            if (!res_valid_q || res_ready) begin
                res_d       = word_w;
                res_valid_d = 1'b1;
`ifdef BDESER_PARITY_EN
                perr_d      = perr_w;
`endif
            end else begin
                overrun_d   = 1'b1;
            end
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            ssl_q       <= 1'b0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef BDESER_PARITY_EN
            perr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            ssl_q       <= ssl_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            overrun_q   <= overrun_d;
`ifdef BDESER_PARITY_EN
            perr_q      <= perr_d;
`endif
        end
    end

    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign overrun   = overrun_q;
`ifdef BDESER_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bdeser.sv
`default_nettype none
// ============================================================================
// Module   : tb_bdeser
// Purpose  : Self-checking bench for bdeser (WIDTH=4). A queue-based model of
//            the word assembly and handshake is compared against the DUT
//            outputs on every falling edge; directed sequences with literal
//            expected words pin the model, followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bdeser;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         sin_valid;
    logic         sin;
    logic         ssl;
    logic         clr;
    logic [W-1:0] res;
    logic         res_valid;
    logic         res_ready;
    logic         overrun;
    logic         parity_err;

    int n_total = 0;
    int n_pass  = 0;

    bdeser #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .sin_valid  (sin_valid),
        .sin        (sin),
        .ssl        (ssl),
        .clr        (clr),
        .res        (res),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: bits of the current word kept in arrival order;
    // the word value is built by positional arithmetic at completion.
    // ------------------------------------------------------------------
    bit           m_q[$];
    bit           m_ord   = 1'b0;
    logic [W-1:0] m_res   = '0;
    bit           m_valid = 1'b0;
    bit           m_ovr   = 1'b0;
    bit           m_perr  = 1'b0;

    function automatic logic [W-1:0] pack_word();
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (m_ord) w[W-1-i] = m_q[i];
            else       w[i]     = m_q[i];
        end
        return w;
    endfunction

    always @(posedge clock or negedge reset) begin : p_model
        bit           done;
        logic [W-1:0] word;
        bit           pe;
        if (!reset) begin
            m_q.delete();
            m_ord   = 1'b0;
            m_res   = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_perr  = 1'b0;
        end else begin
            done = 1'b0;
            word = '0;
            pe   = 1'b0;
            if (clr) begin
                m_q.delete();
            end else if (sin_valid) begin
                if (m_q.size() == 0) m_ord = ssl;
`ifdef BDESER_PARITY_EN
                if (m_q.size() == W) begin
                    word = pack_word();
                    pe   = sin;
                    foreach (m_q[i]) pe = pe ^ m_q[i];
                    done = 1'b1;
                    m_q.delete();
                end else begin
                    m_q.push_back(sin);
                end
`else
                m_q.push_back(sin);
                if (m_q.size() == W) begin
                    word = pack_word();
                    done = 1'b1;
                    m_q.delete();
                end
`endif
            end
            m_ovr = 1'b0;
            if (done) begin
                if (!m_valid || res_ready) begin
                    m_res   = word;
                    m_valid = 1'b1;
                    m_perr  = pe;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && res_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clock) begin
        check("res",        32'(res),        32'(m_res));
        check("res_valid",  32'(res_valid),  32'(m_valid));
        check("overrun",    32'(overrun),    32'(m_ovr));
        check("parity_err", 32'(parity_err), 32'(m_perr));
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send_bit(input logic b, input logic s);
        sin_valid = 1'b1;
        sin       = b;
        ssl       = s;
        @(negedge clock);
        sin_valid = 1'b0;
        sin       = 1'b0;
    endtask

    // Sends seq[W-1] first in time. With parity enabled a parity bit follows
    // (correct even parity when par_ok=1). rdy_last raises res_ready only
    // for the completing bit.
    task automatic send_word(input logic [W-1:0] seq, input logic s,
                             input logic rdy_last, input logic par_ok);
        for (int i = W - 1; i >= 0; i--) begin
`ifndef BDESER_PARITY_EN
            if (i == 0 && rdy_last) res_ready = 1'b1;
`endif
            send_bit(seq[i], s);
        end
`ifdef BDESER_PARITY_EN
        if (rdy_last) res_ready = 1'b1;
        send_bit((^seq) ^ ~par_ok, s);
`endif
        if (rdy_last) res_ready = 1'b0;
    endtask

    task automatic drain();
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_res"},   32'(res),        32'h0);
        check({tag, "_valid"}, 32'(res_valid),  32'h0);
        check({tag, "_ovr"},   32'(overrun),    32'h0);
        check({tag, "_perr"},  32'(parity_err), 32'h0);
    endtask

    initial begin
        reset     = 1'b0;
        sin_valid = 1'b0;
        sin       = 1'b0;
        ssl       = 1'b0;
        clr       = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(negedge clock);
        #1 check_all_zero("por");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // MSB first, 1,0,1,1 -> 1011, visible the cycle after the 4th bit
        send_word(4'b1011, 1'b1, 1'b0, 1'b1);
        check("msb_res",   32'(res),       32'hB);
        check("msb_valid", 32'(res_valid), 32'h1);
        drain();
        check("drain_valid", 32'(res_valid), 32'h0);
        check("drain_res",   32'(res),       32'hB);

        // LSB first, 1,0,1,1 -> 1101
        send_word(4'b1011, 1'b0, 1'b0, 1'b1);
        check("lsb_res", 32'(res), 32'hD);
        drain();

        // ssl flips after the first bit: order stays LSB first
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
`ifdef BDESER_PARITY_EN
        send_bit(1'b1, 1'b1);
`endif
        check("sslflip_res", 32'(res), 32'hD);
        drain();

        // Overrun: 1011 left unread, 0110 dropped
        send_word(4'b1011, 1'b1, 1'b0, 1'b1);
        send_word(4'b0110, 1'b1, 1'b0, 1'b1);
        check("ovr_pulse", 32'(overrun),   32'h1);
        check("ovr_res",   32'(res),       32'hB);
        check("ovr_valid", 32'(res_valid), 32'h1);
        @(negedge clock);
        check("ovr_once",  32'(overrun),   32'h0);

        // Read in the same cycle as completion: new word replaces held one
        send_word(4'b0110, 1'b1, 1'b1, 1'b1);
        check("rdy_res",   32'(res),       32'h6);
        check("rdy_valid", 32'(res_valid), 32'h1);
        check("rdy_ovr",   32'(overrun),   32'h0);
        drain();

        // Reset mid-word discards the partial word
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        #2 reset = 1'b0;
        #1 check_all_zero("rst");
        @(negedge clock);
        reset = 1'b1;
        send_word(4'b0011, 1'b1, 1'b0, 1'b1);
        check("rst_res",   32'(res),       32'h3);
        check("rst_valid", 32'(res_valid), 32'h1);
        drain();

        // clr mid-word with a simultaneous bit, which must be discarded
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        clr = 1'b1;
        send_bit(1'b1, 1'b1);
        clr = 1'b0;
        check("clr_valid", 32'(res_valid), 32'h0);
        send_word(4'b1001, 1'b1, 1'b0, 1'b1);
        check("clr_res", 32'(res), 32'h9);
        drain();

`ifdef BDESER_PARITY_EN
        send_word(4'b1011, 1'b1, 1'b0, 1'b0);
        check("par_bad_res",  32'(res),        32'hB);
        check("par_bad_perr", 32'(parity_err), 32'h1);
        drain();
        send_word(4'b1011, 1'b1, 1'b0, 1'b1);
        check("par_ok_perr",  32'(parity_err), 32'h0);
        drain();
`endif

        // Randomized traffic checked by the model
        for (int c = 0; c < 3000; c++) begin
            sin_valid = ($urandom_range(0, 3) != 0);
            sin       = 1'($urandom_range(0, 1));
            ssl       = 1'($urandom_range(0, 1));
            clr       = ($urandom_range(0, 24) == 0);
            res_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b0;
                @(negedge clock);
                reset = 1'b1;
            end else begin
                @(negedge clock);
            end
        end
        sin_valid = 1'b0;
        clr       = 1'b0;
        res_ready = 1'b0;
        @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
